ram_stream_ctrl: RTL and testbench

Controller sitting directly upstream of the team's 16x8 single-port RAM (sync write, async read). It drives the RAM's we/addr/din from an inbound valid/ready byte stream (LOAD). It also reads the RAM's combinational dout back out as an outbound valid/ready byte stream (DUMP). Used to bulk-fill the RAM at run time and to read its contents back for checking.

---
 rtl/ram_stream_pkg.sv | 18 +
 rtl/ram_stream_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ram_stream_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared state encoding and default sizing for ram_stream_ctrl.
//   state_t      : controller states (idle, stream-in to RAM, stream-out from RAM)
//   DEF_ADDR_W   : default RAM address width
//   DEF_DATA_W   : default RAM data width
//   DEF_DEPTH    : default words per transaction (always 2**DEF_ADDR_W)
package ram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/ram_stream_ctrl.sv
// ram_stream_ctrl: bulk LOAD (stream -> RAM) and DUMP (RAM -> stream) controller for a
// single-port RAM with synchronous write and combinational read.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_load, cmd_dump   start a transaction; sampled only while idle, load has priority
//   abort                synchronous return to idle from any state, no done pulse
//   s_valid/s_data/s_ready   inbound byte stream, written straight into the RAM
//   m_valid/m_data/m_ready   outbound byte stream, registered, read from the RAM
//   ram_we/ram_addr/ram_din  RAM write/address/data-in
//   ram_dout             RAM combinational read data
//   busy                 high while loading or dumping
//   done                 one-cycle pulse after a transaction completes normally
//   csum                 (only with RAM_STREAM_CHECKSUM_EN) mod-2**DATA_W sum of the last load
module ram_stream_ctrl
    import ram_stream_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_load,
    input  logic              cmd_dump,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done
`ifdef RAM_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ISS_MAX = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   iss_q, iss_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              done_q, done_d;
`ifdef RAM_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic wr_hs;
    logic fetch;
    logic accept;

    // Abort suppresses the handshake so a byte offered on the abort cycle is
    // neither written nor consumed.
    assign s_ready  = (state_q == ST_LOAD) && !abort;
    assign wr_hs    = s_ready && s_valid;
    assign ram_we   = wr_hs;
    assign ram_addr = (state_q == ST_DUMP) ? rd_ptr_q : wr_ptr_q;
    assign ram_din  = s_data;

    // The output register is one beat deep: refill it when empty or being drained.
    assign fetch  = (state_q == ST_DUMP) && (iss_q < ISS_MAX) && (!m_valid_q || m_ready);
    assign accept = m_valid_q && m_ready;

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
`ifdef RAM_STREAM_CHECKSUM_EN
    assign csum    = csum_q;
`endif

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        iss_d     = iss_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        done_d    = 1'b0;
`ifdef RAM_STREAM_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        if (abort) begin
            state_d   = ST_IDLE;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            iss_d     = '0;
            m_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_load) begin
                        state_d  = ST_LOAD;
                        wr_ptr_d = '0;
`ifdef RAM_STREAM_CHECKSUM_EN
                        csum_d   = '0;
`endif
                    end else if (cmd_dump) begin
                        state_d  = ST_DUMP;
                        rd_ptr_d = '0;
                        iss_d    = '0;
                    end
                end
                ST_LOAD: begin
                    if (wr_hs) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef RAM_STREAM_CHECKSUM_EN
                        csum_d   = csum_q + s_data;
`endif
                        if (wr_ptr_q == LAST) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DUMP: begin
                    if (fetch) begin
                        m_data_d  = ram_dout;
                        m_valid_d = 1'b1;
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                        iss_d     = iss_q + 1'b1;
                    end else if (accept) begin
                        m_valid_d = 1'b0;
                        // With every word issued, the beat just accepted is the last one.
                        if (iss_q == ISS_MAX) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            iss_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            done_q    <= 1'b0;
`ifdef RAM_STREAM_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            iss_q     <= iss_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            done_q    <= done_d;
`ifdef RAM_STREAM_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// tb_ram_stream_ctrl: directed/randomized bench for ram_stream_ctrl with a behavioural RAM
// and a reference image of the expected RAM contents and load checksum.
module tb_ram_stream_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_load = 1'b0;
    logic          cmd_dump = 1'b0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;
    logic          done;
`ifdef RAM_STREAM_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] stim    [DEPTH];
    logic [DW-1:0] ref_csum;

    ram_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_load(cmd_load), .cmd_dump(cmd_dump), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .done(done)
`ifdef RAM_STREAM_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem();
        for (int i = 0; i < DEPTH; i++) chk("mem_image", mem[i], ref_mem[i]);
    endtask

    // gap_mode: 0 none, 1 fixed 3 idle cycles before each beat, 2 random 0..3
    task automatic run_load(input int gap_mode, input int abort_after, input bit both_cmds);
        int gap;
        @(negedge clk);
        cmd_load = 1'b1;
        cmd_dump = both_cmds;
        @(negedge clk);
        cmd_load = 1'b0;
        cmd_dump = 1'b0;
        #1 chk("load_busy", busy, 1);
        chk("load_ready", s_ready, 1);
        ref_csum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == abort_after) begin
                s_valid = 1'b1;
                s_data = stim[i];
                abort = 1'b1;
                #1 chk("abort_we", ram_we, 0);
                @(negedge clk);
                abort = 1'b0;
                s_valid = 1'b0;
                cmd_dump = 1'b0;
                #1 chk("abort_idle", busy, 0);
                chk("abort_no_done", done, 0);
                @(negedge clk);
                #1 chk("abort_no_done_late", done, 0);
                return;
            end
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 3 : int'($urandom_range(3, 0));
            repeat (gap) begin
                s_valid = 1'b0;
                cmd_dump = 1'($urandom_range(1, 0));
                #1 chk("gap_no_we", ram_we, 0);
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data = stim[i];
            cmd_dump = 1'($urandom_range(1, 0));
            #1 chk("beat_busy", busy, 1);
            chk("beat_we", ram_we, 1);
            chk("beat_addr", ram_addr, i);
            chk("beat_din", ram_din, stim[i]);
            @(negedge clk);
            ref_mem[i] = stim[i];
            ref_csum = ref_csum + stim[i];
        end
        s_valid = 1'b0;
        cmd_dump = 1'b0;
        #1 chk("load_done", done, 1);
        chk("load_done_not_busy", busy, 0);
`ifdef RAM_STREAM_CHECKSUM_EN
        chk("load_csum", csum, ref_csum);
`endif
        @(negedge clk);
        #1 chk("load_done_one_cycle", done, 0);
    endtask

    // mode: 0 m_ready always 1, 1 toggling 1/0, 2 random
    task automatic run_dump(input int mode);
        int got;
        int cyc;
        bit prev_stall;
        logic [DW-1:0] prev_data;
        got = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        @(negedge clk);
        cmd_dump = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        cmd_dump = 1'b0;
        #1 chk("dump_busy", busy, 1);
        chk("dump_first_empty", m_valid, 0);
        chk("dump_no_ready_in", s_ready, 0);
        while (got < DEPTH && cyc < 200) begin
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'($urandom_range(1, 0));
            #1;
            if (prev_stall) chk("dump_stall_hold", {m_valid, m_data}, {1'b1, prev_data});
            if (m_valid) begin
                chk("dump_data", m_data, ref_mem[got]);
                if (m_ready) got++;
            end
            if (cyc % 4 == 0) chk("dump_no_we", ram_we, 0);
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            cyc++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("dump_beats", got, DEPTH);
        if (mode == 0) chk("dump_cycles", cyc, DEPTH + 1);
        #1 chk("dump_done", done, 1);
        chk("dump_done_not_busy", busy, 0);
        chk("dump_done_no_valid", m_valid, 0);
        @(negedge clk);
        #1 chk("dump_done_one_cycle", done, 0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #1 chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef RAM_STREAM_CHECKSUM_EN
        chk("rst_csum", csum, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // ascending load, no gaps
        for (int i = 0; i < DEPTH; i++) stim[i] = DW'(i);
        run_load(0, -1, 1'b0);
        chk_mem();

        run_dump(0);
        run_dump(1);

        // simultaneous commands, random data, fixed gaps of 3
        for (int i = 0; i < DEPTH; i++) stim[i] = DW'($urandom);
        run_load(1, -1, 1'b1);
        chk_mem();
        run_dump(2);

        // random data with random gaps
        for (int i = 0; i < DEPTH; i++) stim[i] = DW'($urandom);
        run_load(2, -1, 1'b0);
        run_dump(2);

        // abort after 5 beats: only the first five words change
        for (int i = 0; i < DEPTH; i++) stim[i] = DW'($urandom);
        run_load(0, 5, 1'b0);
        chk_mem();
        run_dump(0);

        // abort mid-dump
        @(negedge clk);
        cmd_dump = 1'b1;
        @(negedge clk);
        cmd_dump = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("dump_abort_pre_valid", m_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1 chk("dump_abort_valid", m_valid, 0);
        chk("dump_abort_busy", busy, 0);
        chk("dump_abort_done", done, 0);

        // reset mid-dump takes effect immediately
        @(negedge clk);
        cmd_dump = 1'b1;
        @(negedge clk);
        cmd_dump = 1'b0;
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        m_ready = 1'b0;
        #1 chk("rst_mid_pre_valid", m_valid, 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", ram_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_dump(2);

        // checksum corner patterns
        for (int i = 0; i < DEPTH; i++) stim[i] = 8'hF0;
        run_load(2, -1, 1'b0);
`ifdef RAM_STREAM_CHECKSUM_EN
        chk("csum_f0", csum, 8'h00);
`endif
        for (int i = 0; i < DEPTH; i++) stim[i] = DW'(i + 1);
        run_load(0, -1, 1'b0);
        run_dump(1);
`ifdef RAM_STREAM_CHECKSUM_EN
        chk("csum_1_to_16_held", csum, 8'h88);
`endif
        chk_mem();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
